instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC, IF/ID register and range/alignment fault capture.
// Optional: define FETCH_ALIGN_CHECK_EN to halt on misaligned redirect targets instead of truncating them.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic        fault,
    output logic [63:0] fault_pc
);

    localparam logic [63:0] LAST_PC = 64'(MEM_LIMIT) - 64'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic        if_valid_q;
    logic [63:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        halted_q;
    logic        fault_q;
    logic [63:0] fault_pc_q;

    logic [63:0] pc_inc_d;
    logic [63:0] redir_pc_d;
    logic        misaligned_d;
    logic        out_of_range_d;

    always_comb begin
        pc_inc_d       = pc_q + 64'd4;
        redir_pc_d     = redirect_pc & ~64'h3;
        out_of_range_d = (pc_q > LAST_PC);
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned_d   = (redirect_pc[1:0] != 2'b00);
`else
        misaligned_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // Priority: redirect > range fault > stall > advance.
                    if (redirect && misaligned_d) begin
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        fault_q    <= 1'b1;
                        fault_pc_q <= redirect_pc;
                        if_valid_q <= 1'b0;
                    end else if (redirect) begin
                        pc_q       <= redir_pc_d;
                        if_valid_q <= 1'b0;
                    end else if (out_of_range_d) begin
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                        if_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if_instr_q <= imem_data;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_inc_d;
                    end
                end
                HALT: begin
                    halted_q   <= 1'b1;
                    if_valid_q <= 1'b0;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cold start, stall, redirect, range fault, async reset, alignment.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic        fault;
    logic [63:0] fault_pc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // Memory image: word 0 is 32'h00002003, every other word holds 32'h1000_0000 + its address.
    assign imem_data = (imem_addr == 64'h0) ? 32'h00002003 : 32'h1000_0000 + imem_addr[31:0];

    instruction_fetch #(
        .RESET_PC (64'h0),
        .MEM_LIMIT(256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .halted     (halted),
        .fault      (fault),
        .fault_pc   (fault_pc)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_addr",   imem_addr, 64'h0);
        check_eq("rst_valid",  64'(if_valid), 64'h0);
        check_eq("rst_ifpc",   if_pc, 64'h0);
        check_eq("rst_instr",  64'(if_instr), 64'h0);
        check_eq("rst_halted", 64'(halted), 64'h0);
        check_eq("rst_fault",  64'(fault), 64'h0);
        check_eq("rst_fpc",    fault_pc, 64'h0);
        rst_n = 1'b1;

        // Cold start: BOOT edge, then advancing RUN edges
        @(negedge clk);
        check_eq("boot_addr",  imem_addr, 64'h0);
        check_eq("boot_valid", 64'(if_valid), 64'h0);
        @(negedge clk);
        check_eq("cs1_addr",   imem_addr, 64'h4);
        check_eq("cs1_valid",  64'(if_valid), 64'h1);
        check_eq("cs1_ifpc",   if_pc, 64'h0);
        check_eq("cs1_instr",  64'(if_instr), 64'h00002003);
        @(negedge clk);
        check_eq("cs2_addr",   imem_addr, 64'h8);
        check_eq("cs2_ifpc",   if_pc, 64'h4);
        check_eq("cs2_instr",  64'(if_instr), 64'h10000004);

        // Stall for three edges with PC=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stl_addr",  imem_addr, 64'h8);
            check_eq("stl_ifpc",  if_pc, 64'h4);
            check_eq("stl_valid", 64'(if_valid), 64'h1);
        end
        stall = 1'b0;
        @(negedge clk);
        check_eq("rel_ifpc",  if_pc, 64'h8);
        check_eq("rel_instr", 64'(if_instr), 64'h10000008);
        check_eq("rel_addr",  imem_addr, 64'hC);

        // Redirect while stalled
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h30;
        @(negedge clk);
        check_eq("rds_addr",  imem_addr, 64'h30);
        check_eq("rds_valid", 64'(if_valid), 64'h0);
        check_eq("rds_ifpc",  if_pc, 64'h8);
        redirect = 1'b0;
        @(negedge clk);
        check_eq("rds2_addr", imem_addr, 64'h30);
        check_eq("rds2_valid", 64'(if_valid), 64'h0);
        stall = 1'b0;
        @(negedge clk);
        check_eq("rdr_ifpc",  if_pc, 64'h30);
        check_eq("rdr_valid", 64'(if_valid), 64'h1);
        check_eq("rdr_instr", 64'(if_instr), 64'h10000030);
        check_eq("rdr_addr",  imem_addr, 64'h34);

        // Range fault: last legal word 0xFC, then 0x100 faults
        redirect    = 1'b1;
        redirect_pc = 64'hFC;
        @(negedge clk);
        check_eq("rng_addr", imem_addr, 64'hFC);
        redirect = 1'b0;
        @(negedge clk);
        check_eq("rng_ifpc",   if_pc, 64'hFC);
        check_eq("rng_valid",  64'(if_valid), 64'h1);
        check_eq("rng_halt0",  64'(halted), 64'h0);
        check_eq("rng_addr2",  imem_addr, 64'h100);
        @(negedge clk);
        check_eq("flt_halted", 64'(halted), 64'h1);
        check_eq("flt_fault",  64'(fault), 64'h1);
        check_eq("flt_fpc",    fault_pc, 64'h100);
        check_eq("flt_valid",  64'(if_valid), 64'h0);

        // HALT is sticky: redirect and stall ignored
        for (int i = 0; i < 10; i++) begin
            stall       = i[0];
            redirect    = 1'b1;
            redirect_pc = 64'h40;
            @(negedge clk);
            check_eq("hlt_halted", 64'(halted), 64'h1);
            check_eq("hlt_fault",  64'(fault), 64'h1);
            check_eq("hlt_fpc",    fault_pc, 64'h100);
            check_eq("hlt_valid",  64'(if_valid), 64'h0);
            check_eq("hlt_addr",   imem_addr, 64'h100);
        end

        // Asynchronous reset between edges, with a redirect pending
        redirect_pc = 64'h80;
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_halted", 64'(halted), 64'h0);
        check_eq("ar_fault",  64'(fault), 64'h0);
        check_eq("ar_valid",  64'(if_valid), 64'h0);
        check_eq("ar_addr",   imem_addr, 64'h0);
        check_eq("ar_fpc",    fault_pc, 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        check_eq("ar_boot_addr", imem_addr, 64'h0);
        @(negedge clk);
        check_eq("ar_run_addr",  imem_addr, 64'h4);
        check_eq("ar_run_ifpc",  if_pc, 64'h0);
        check_eq("ar_run_instr", 64'(if_instr), 64'h00002003);

        // Misaligned redirect target 0x32
        redirect    = 1'b1;
        redirect_pc = 64'h32;
        @(negedge clk);
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("al_fault",  64'(fault), 64'h1);
        check_eq("al_fpc",    fault_pc, 64'h32);
        check_eq("al_halted", 64'(halted), 64'h1);
        check_eq("al_addr",   imem_addr, 64'h4);
        @(negedge clk);
        check_eq("al_valid",  64'(if_valid), 64'h0);
        check_eq("al_addr2",  imem_addr, 64'h4);
`else
        check_eq("al_addr",   imem_addr, 64'h30);
        check_eq("al_fault",  64'(fault), 64'h0);
        check_eq("al_halted", 64'(halted), 64'h0);
        @(negedge clk);
        check_eq("al_ifpc",   if_pc, 64'h30);
        check_eq("al_instr",  64'(if_instr), 64'h10000030);
        check_eq("al_fault2", 64'(fault), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
